// File: rtl/uart_rx_arbiter_if.sv
// Output handshake bundle of the UART receive arbiter.
// Carries the granted byte, its source channel and the valid/ready pair.
interface uart_rx_arbiter_if #(
  parameter int width  = 8,
  parameter int NUM_CH = 4
);
  localparam int CW = $clog2(NUM_CH);

  logic [width-1:0] Out_Data;
  logic [CW-1:0]    Out_Ch;
  logic             Out_Valid;
  logic             Out_Ready;

  modport master (
    output Out_Data,
    output Out_Ch,
    output Out_Valid,
    input  Out_Ready
  );

  modport slave (
    input  Out_Data,
    input  Out_Ch,
    input  Out_Valid,
    output Out_Ready
  );
endinterface

// File: rtl/uart_rx_arbiter.sv
// Merges NUM_CH UART receive streams into one registered output.
// Per-channel 1-entry holding registers, round-robin grant, sticky overrun.
module uart_rx_arbiter #(
  parameter  int width  = 8,
  parameter  int NUM_CH = 4,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*width-1:0] Ch_Data,
  input  logic [NUM_CH-1:0]       Ch_Valid,
  uart_rx_arbiter_if.master       out_if,
  output logic [NUM_CH-1:0]       Overrun,
  input  logic [NUM_CH-1:0]       Overrun_Clr
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CH-1:0]            pend_q, pend_d;
  logic [NUM_CH-1:0][width-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0]            ovr_q, ovr_d;
  logic [NUM_CH-1:0]            ovr_set;
  logic [CW-1:0]                last_q, last_d;
  logic [width-1:0]             data_q, data_d;
  logic [CW-1:0]                ch_q, ch_d;
  logic [CW-1:0]                win, cand;
  logic                         win_vld;
  logic                         load;

  assign out_if.Out_Data = data_q;
  assign out_if.Out_Ch   = ch_q;
  assign Overrun         = ovr_q;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    win     = last_q;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CW'((int'(last_q) + k) % NUM_CH);
      if (!win_vld && pend_q[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Output register is free when empty or being consumed this cycle
  assign load = win_vld &&
                ((state_q == IDLE) || out_if.Out_Ready);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = PRESENT;
      PRESENT: if (out_if.Out_Ready && !load)
                 state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    out_if.Out_Valid = (state_q == PRESENT);
  end

  // Capture, load and overrun next-state
  always_comb begin
    pend_d  = pend_q;
    hold_d  = hold_q;
    last_d  = last_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ovr_set = '0;
    if (load) begin
      pend_d[win] = 1'b0;
      last_d      = win;
      data_d      = hold_q[win];
      ch_d        = win;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (Ch_Valid[i]) begin
        if (!pend_q[i] || (load && win == CW'(i))) begin
          hold_d[i] = Ch_Data[i*width +: width];
          pend_d[i] = 1'b1;
        end else begin
          ovr_set[i] = 1'b1;
        end
      end
    end
    ovr_d = (ovr_q & ~Overrun_Clr) | ovr_set;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      hold_q <= '0;
      ovr_q  <= '0;
      last_q <= CW'(NUM_CH - 1);
      data_q <= '0;
      ch_q   <= '0;
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
      ovr_q  <= ovr_d;
      last_q <= last_d;
      data_q <= data_d;
      ch_q   <= ch_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// Testbench for uart_rx_arbiter.
// Directed literal cases plus randomized traffic against a behavioural model.
module tb_uart_rx_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N*W-1:0] ch_data;
  logic [N-1:0] ch_valid, ovr, clr;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_rx_arbiter_if #(.width(W), .NUM_CH(N)) bus ();

  uart_rx_arbiter #(.width(W), .NUM_CH(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Ch_Data    (ch_data),
    .Ch_Valid   (ch_valid),
    .out_if     (bus),
    .Overrun    (ovr),
    .Overrun_Clr(clr)
  );

  typedef struct packed {
    logic [N-1:0]        pend;
    logic [N-1:0][W-1:0] hold;
    logic [N-1:0]        ovr;
    int                  last;
    logic                mv;
    logic [W-1:0]        md;
    int                  mc;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(mdl_t s, logic rn,
                                logic [N-1:0] v,
                                logic [N*W-1:0] d,
                                logic rdy,
                                logic [N-1:0] cl);
    mdl_t n;
    int win;
    int c;
    logic [N-1:0] set;
    n = s;
    win = -1;
    set = '0;
    if (!rn) begin
      n = '0;
      n.last = N - 1;
      return n;
    end
    if ((!s.mv || rdy) && s.pend != '0)
      for (int k = 1; k <= N; k++) begin
        c = (s.last + k) % N;
        if (win < 0 && s.pend[c]) win = c;
      end
    if (win >= 0) begin
      n.mv = 1'b1;
      n.md = s.hold[win];
      n.mc = win;
      n.last = win;
      n.pend[win] = 1'b0;
    end else if (s.mv && rdy) begin
      n.mv = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (v[i]) begin
        if (!s.pend[i] || win == i) begin
          n.hold[i] = d[i*W +: W];
          n.pend[i] = 1'b1;
        end else begin
          set[i] = 1'b1;
        end
      end
    n.ovr = (s.ovr & ~cl) | set;
    return n;
  endfunction

  always @(posedge clk)
    m <= step(m, rst_n, ch_valid, ch_data,
              bus.Out_Ready, clr);

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({bus.Out_Valid, bus.Out_Ch, bus.Out_Data, ovr} !==
          {m.mv, 2'(m.mc), m.md, m.ovr}) begin
        errors++;
        $display("FAIL model t=%0t got v=%b ch=%0d d=%h ovr=%b exp v=%b ch=%0d d=%h ovr=%b",
                 $time, bus.Out_Valid, bus.Out_Ch, bus.Out_Data, ovr,
                 m.mv, m.mc, m.md, m.ovr);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ch_valid = '0;
    clr = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    ch_valid = 4'hF;
    ch_data = 32'hDEADBEEF;
    clr = '0;
    bus.Out_Ready = 1'b1;
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    ch_valid = '0;
    chk("rst_valid", 32'(bus.Out_Valid), 0);
    chk("rst_data", 32'(bus.Out_Data), 0);
    chk("rst_ch", 32'(bus.Out_Ch), 0);
    chk("rst_ovr", 32'(ovr), 0);
    repeat (3) tick();
    chk("rst_ignore", 32'(bus.Out_Valid), 0);

    // single byte, 2-cycle latency
    ch_data[2*W +: W] = 8'hA5;
    ch_valid = 4'b0100;
    tick();
    ch_valid = '0;
    chk("single_t1", 32'(bus.Out_Valid), 0);
    tick();
    chk("single_v", 32'(bus.Out_Valid), 1);
    chk("single_d", 32'(bus.Out_Data), 32'hA5);
    chk("single_ch", 32'(bus.Out_Ch), 2);
    tick();
    chk("single_end", 32'(bus.Out_Valid), 0);

    // simultaneous on all channels
    do_reset();
    ch_data = 32'h13121110;
    ch_valid = 4'hF;
    tick();
    ch_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("simul_v", 32'(bus.Out_Valid), 1);
      chk("simul_d", 32'(bus.Out_Data), 32'h10 + k);
      chk("simul_ch", 32'(bus.Out_Ch), k);
    end
    tick();
    chk("simul_end", 32'(bus.Out_Valid), 0);

    // fairness between ch0 and ch3
    do_reset();
    ch_valid = 4'b1001;
    tick();
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("fair_ch", 32'(bus.Out_Ch), (g % 2 == 0) ? 0 : 3);
    end
    ch_valid = '0;
    repeat (3) tick();

    // backpressure, overrun, set-wins
    do_reset();
    bus.Out_Ready = 1'b0;
    ch_data[1*W +: W] = 8'h55;
    ch_valid = 4'b0010;
    tick();
    ch_valid = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_v", 32'(bus.Out_Valid), 1);
      chk("bp_d", 32'(bus.Out_Data), 32'h55);
      chk("bp_ch", 32'(bus.Out_Ch), 1);
      tick();
    end
    ch_data[1*W +: W] = 8'h01;
    ch_valid = 4'b0010;
    tick();
    ch_data[1*W +: W] = 8'h02;
    tick();
    ch_valid = '0;
    chk("ovr_set", 32'(ovr[1]), 1);
    ch_data[2*W +: W] = 8'h77;
    ch_valid = 4'b0100;
    tick();
    ch_data[2*W +: W] = 8'h78;
    clr = 4'b0100;
    tick();
    ch_valid = '0;
    clr = '0;
    chk("ovr_setwins", 32'(ovr[2]), 1);
    bus.Out_Ready = 1'b1;
    tick();
    chk("ovr_d1", 32'(bus.Out_Data), 32'h77);
    chk("ovr_ch1", 32'(bus.Out_Ch), 2);
    tick();
    chk("ovr_d2", 32'(bus.Out_Data), 32'h01);
    chk("ovr_ch2", 32'(bus.Out_Ch), 1);
    clr = 4'b0010;
    tick();
    clr = '0;
    chk("ovr_clr1", 32'(ovr[1]), 0);
    chk("ovr_keep2", 32'(ovr[2]), 1);

    // reset mid-transfer
    do_reset();
    bus.Out_Ready = 1'b0;
    ch_data[0 +: W] = 8'h33;
    ch_valid = 4'b0001;
    tick();
    ch_valid = 4'b0110;
    tick();
    ch_valid = '0;
    chk("mid_v", 32'(bus.Out_Valid), 1);
    rst_n = 1'b0;
    ch_valid = 4'hF;
    tick();
    rst_n = 1'b1;
    ch_valid = '0;
    bus.Out_Ready = 1'b1;
    chk("mid_rst_v", 32'(bus.Out_Valid), 0);
    chk("mid_rst_d", 32'(bus.Out_Data), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_quiet", 32'(bus.Out_Valid), 0);
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < N; i++)
        ch_valid[i] = ($urandom_range(0, 99) < 30);
      ch_data = $urandom;
      bus.Out_Ready = ($urandom_range(0, 99) < 65);
      for (int i = 0; i < N; i++)
        clr[i] = ($urandom_range(0, 99) < 8);
      tick();
    end
    ch_valid = '0;
    clr = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
